// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states and port identifiers.
package mem_port_arbiter_pkg;

  // 2'd3 is unused and decodes back to S_IDLE in the FSM.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Port 0 is instruction fetch, port 1 is data load/store.
  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

  localparam int DWIDTH  = 32;
  localparam int BEWIDTH = 4;

  // The port that did not win last time.
  function automatic port_e other_port(input port_e p);
    return (p == PORT_IF) ? PORT_MEM : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. The history register lives in the top.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last,
  output logic       gnt_valid,
  output port_e      gnt_id
);

  // A lone requester wins; on a tie the port not served last wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = |req;
    gnt_id    = PORT_IF;
    if (req == 2'b11) begin
      gnt_id = other_port(last);
    end else if (req[1]) begin
      gnt_id = PORT_MEM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one latency-modelled single-port SRAM between instruction fetch (port 0)
// and data load/store (port 1): round-robin grant, CSN held low until READY,
// then a one-cycle ACK carrying the read data back to the winner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int LAT    = 2    // legal range 1..7
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               P0_REQ,
  input  logic               P0_WEN,
  input  logic [BEWIDTH-1:0] P0_BE,
  input  logic [AWIDTH-1:0]  P0_ADDR,
  input  logic [DWIDTH-1:0]  P0_DI,
  output logic               P0_ACK,
  input  logic               P1_REQ,
  input  logic               P1_WEN,
  input  logic [BEWIDTH-1:0] P1_BE,
  input  logic [AWIDTH-1:0]  P1_ADDR,
  input  logic [DWIDTH-1:0]  P1_DI,
  output logic               P1_ACK,
  output logic [DWIDTH-1:0]  P_DOUT,
  output logic               M_CSN,
  output logic [AWIDTH-1:0]  M_ADDR,
  output logic               M_WEN,
  output logic [BEWIDTH-1:0] M_BE,
  output logic [DWIDTH-1:0]  M_DI,
  input  logic [DWIDTH-1:0]  M_DOUT,
  input  logic               M_READY,
  output logic [2:0]         M_LATENCY,
  output logic               BUSY
);

  state_e              state_q, state_d;
  port_e               gid_q, last_q, gnt_id;
  logic                gnt_valid;

  logic                sel_wen;
  logic [BEWIDTH-1:0]  sel_be;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_di;

  logic                cmd_wen_q;
  logic [BEWIDTH-1:0]  cmd_be_q;
  logic [AWIDTH-1:0]   cmd_addr_q;
  logic [DWIDTH-1:0]   cmd_di_q;

  mem_port_arbiter_rr_arb2 u_arb (
    .req       ({P1_REQ, P0_REQ}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the winner's request fields toward the command registers.
  always_comb begin
    sel_wen  = P0_WEN;
    sel_be   = P0_BE;
    sel_addr = P0_ADDR;
    sel_di   = P0_DI;
    if (gnt_id == PORT_MEM) begin
      sel_wen  = P1_WEN;
      sel_be   = P1_BE;
      sel_addr = P1_ADDR;
      sel_di   = P1_DI;
    end
  end

  // Next state: grant only from IDLE, wait in ACCESS for READY, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_valid) state_d = S_ACCESS;
      S_ACCESS: if (M_READY)   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; asserting reset drops CSN and any ACK at once via the output decode.
  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: clocked state uses <= so every register samples the pre-edge values.
    if (!RSTn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command registers: capture the winner's request at grant and hold it for the whole access,
  // so a requester that changes or drops its inputs mid-access cannot disturb the SRAM.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_wen_q  <= 1'b1;
      cmd_be_q   <= '0;
      cmd_addr_q <= '0;
      cmd_di_q   <= '0;
      gid_q      <= PORT_IF;
    end else if ((state_q == S_IDLE) && gnt_valid) begin
      cmd_wen_q  <= sel_wen;
      cmd_be_q   <= sel_be;
      cmd_addr_q <= sel_addr;
      cmd_di_q   <= sel_di;
      gid_q      <= gnt_id;
    end
  end

  // Round-robin history: the port acked most recently loses the next tie.
  // Resetting to PORT_MEM lets port 0 win the first tie.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_q <= PORT_MEM;
    end else if (state_q == S_RESP) begin
      last_q <= gid_q;
    end
  end

  // CSN is low only in ACCESS, so it always rises for at least the RESP cycle between
  // accesses and the SRAM's latency counter restarts.
  assign M_CSN     = (state_q != S_ACCESS);
  assign M_ADDR    = cmd_addr_q;
  assign M_WEN     = cmd_wen_q;
  assign M_BE      = cmd_be_q;
  assign M_DI      = cmd_di_q;
  assign M_LATENCY = 3'(LAT);

  // The SRAM output register holds while CSN is high, so RESP can pass it straight through.
  assign P_DOUT = M_DOUT;
  assign P0_ACK = (state_q == S_RESP) && (gid_q == PORT_IF);
  assign P1_ACK = (state_q == S_RESP) && (gid_q == PORT_MEM);
  assign BUSY   = (state_q != S_IDLE);

endmodule
